fetch_realigner: RTL and testbench

- Sits between the instruction-fetch data path and the issue/decode stage.
- Accepts 32-bit halfword-addressed fetch words and splits each into 16-bit and 32-bit instructions, including 32-bit instructions that straddle two fetch words.
- Drives every extracted instruction through one compressed_decoder instance.
- Presents one expanded instruction per cycle on a valid/ready output register.

---
 rtl/fetch_realigner_pkg.sv | 32 +++
 rtl/fetch_realigner_compressed_decoder.sv | 125 ++++++++++++
 rtl/fetch_realigner.sv | 201 ++++++++++++++++++++
 tb/tb_fetch_realigner.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_realigner_pkg.sv
// Shared types and constants for the fetch realigner and its compressed decoder.
// Holds the output-register entry layout, the halfwords-per-fetch-word count and
// the RV base opcodes the decoder expands compressed instructions into.
package fetch_realigner_pkg;

  localparam int FETCH_HW_PER_WORD = 2;

  // Width of the address field stored in an output entry; the top-level VLEN
  // must not exceed this.
  localparam int FR_VLEN = 64;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;

  typedef struct packed {
    logic [FR_VLEN-1:0] addr;
    logic [31:0]        instr;
    logic               is_compressed;
    logic               illegal;
  } fetch_realign_entry_t;

endpackage

// File: rtl/fetch_realigner_compressed_decoder.sv
// Expands RV64C compressed instructions to their 32-bit equivalents.
// Latency: purely combinational. Backpressure: none (no handshake).
// Ports: instr_i (32-bit word, lower half is the compressed candidate),
//   instr_o (expanded, or zero-extended raw halfword if illegal),
//   illegal_instr_o, is_compressed_o (instr_i[1:0] != 2'b11).
module compressed_decoder
  import fetch_realigner_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [31:0] instr_o,
  output logic        illegal_instr_o,
  output logic        is_compressed_o
);

  logic [15:0] c;
  logic [31:0] x_instr;
  logic        x_ill;

  assign c = instr_i[15:0];

  always_comb begin
    x_instr = 32'h0;
    x_ill   = 1'b0;
    case (c[1:0])
      2'b00: begin
        case (c[15:13])
          3'b000: begin // c.addi4spn; a zero immediate (incl. all-zero halfword) is illegal
            x_instr = {2'b0, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'd2, 3'b000, 2'b01, c[4:2], OPC_OP_IMM};
            x_ill   = (c[12:5] == 8'h0);
          end
          3'b001: x_instr = {4'b0, c[6:5], c[12:10], 3'b000, 2'b01, c[9:7], 3'b011, 2'b01, c[4:2], OPC_LOAD_FP};
          3'b010: x_instr = {5'b0, c[5], c[12:10], c[6], 2'b00, 2'b01, c[9:7], 3'b010, 2'b01, c[4:2], OPC_LOAD};
          3'b011: x_instr = {4'b0, c[6:5], c[12:10], 3'b000, 2'b01, c[9:7], 3'b011, 2'b01, c[4:2], OPC_LOAD};
          3'b101: x_instr = {4'b0, c[6:5], c[12], 2'b01, c[4:2], 2'b01, c[9:7], 3'b011, c[11:10], 3'b000, OPC_STORE_FP};
          3'b110: x_instr = {5'b0, c[5], c[12], 2'b01, c[4:2], 2'b01, c[9:7], 3'b010, c[11:10], c[6], 2'b00, OPC_STORE};
          3'b111: x_instr = {4'b0, c[6:5], c[12], 2'b01, c[4:2], 2'b01, c[9:7], 3'b011, c[11:10], 3'b000, OPC_STORE};
          default: x_ill = 1'b1;
        endcase
      end
      2'b01: begin
        case (c[15:13])
          3'b000: x_instr = {{6{c[12]}}, c[12], c[6:2], c[11:7], 3'b000, c[11:7], OPC_OP_IMM};
          3'b001: begin // c.addiw, rd=0 reserved
            x_instr = {{6{c[12]}}, c[12], c[6:2], c[11:7], 3'b000, c[11:7], OPC_OP_IMM32};
            x_ill   = (c[11:7] == 5'd0);
          end
          3'b010: x_instr = {{6{c[12]}}, c[12], c[6:2], 5'd0, 3'b000, c[11:7], OPC_OP_IMM};
          3'b011: begin
            if (c[11:7] == 5'd2) begin // c.addi16sp
              x_instr = {{2{c[12]}}, c[12], c[4:3], c[5], c[2], c[6], 4'b0, 5'd2, 3'b000, 5'd2, OPC_OP_IMM};
            end else begin // c.lui
              x_instr = {{14{c[12]}}, c[12], c[6:2], c[11:7], OPC_LUI};
            end
            x_ill = ({c[12], c[6:2]} == 6'd0);
          end
          3'b100: begin
            case (c[11:10])
              2'b00: x_instr = {6'b000000, c[12], c[6:2], 2'b01, c[9:7], 3'b101, 2'b01, c[9:7], OPC_OP_IMM};
              2'b01: x_instr = {6'b010000, c[12], c[6:2], 2'b01, c[9:7], 3'b101, 2'b01, c[9:7], OPC_OP_IMM};
              2'b10: x_instr = {{6{c[12]}}, c[12], c[6:2], 2'b01, c[9:7], 3'b111, 2'b01, c[9:7], OPC_OP_IMM};
              default: begin
                case ({c[12], c[6:5]})
                  3'b000: x_instr = {7'b0100000, 2'b01, c[4:2], 2'b01, c[9:7], 3'b000, 2'b01, c[9:7], OPC_OP};
                  3'b001: x_instr = {7'b0000000, 2'b01, c[4:2], 2'b01, c[9:7], 3'b100, 2'b01, c[9:7], OPC_OP};
                  3'b010: x_instr = {7'b0000000, 2'b01, c[4:2], 2'b01, c[9:7], 3'b110, 2'b01, c[9:7], OPC_OP};
                  3'b011: x_instr = {7'b0000000, 2'b01, c[4:2], 2'b01, c[9:7], 3'b111, 2'b01, c[9:7], OPC_OP};
                  3'b100: x_instr = {7'b0100000, 2'b01, c[4:2], 2'b01, c[9:7], 3'b000, 2'b01, c[9:7], OPC_OP32};
                  3'b101: x_instr = {7'b0000000, 2'b01, c[4:2], 2'b01, c[9:7], 3'b000, 2'b01, c[9:7], OPC_OP32};
                  default: x_ill = 1'b1;
                endcase
              end
            endcase
          end
          3'b101: x_instr = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], c[12], {8{c[12]}}, 5'd0, OPC_JAL};
          default: // c.beqz / c.bnez, funct3 taken from c[13]
            x_instr = {{4{c[12]}}, c[6:5], c[2], 5'd0, 2'b01, c[9:7], 2'b00, c[13], c[11:10], c[4:3], c[12], OPC_BRANCH};
        endcase
      end
      2'b10: begin
        case (c[15:13])
          3'b000: x_instr = {6'b0, c[12], c[6:2], c[11:7], 3'b001, c[11:7], OPC_OP_IMM};
          3'b001: x_instr = {3'b0, c[4:2], c[12], c[6:5], 3'b000, 5'd2, 3'b011, c[11:7], OPC_LOAD_FP};
          3'b010: begin
            x_instr = {4'b0, c[3:2], c[12], c[6:4], 2'b00, 5'd2, 3'b010, c[11:7], OPC_LOAD};
            x_ill   = (c[11:7] == 5'd0);
          end
          3'b011: begin
            x_instr = {3'b0, c[4:2], c[12], c[6:5], 3'b000, 5'd2, 3'b011, c[11:7], OPC_LOAD};
            x_ill   = (c[11:7] == 5'd0);
          end
          3'b100: begin
            if (!c[12]) begin
              if (c[6:2] == 5'd0) begin // c.jr
                x_instr = {12'b0, c[11:7], 3'b000, 5'd0, OPC_JALR};
                x_ill   = (c[11:7] == 5'd0);
              end else begin // c.mv
                x_instr = {7'b0, c[6:2], 5'd0, 3'b000, c[11:7], OPC_OP};
              end
            end else if (c[6:2] == 5'd0) begin
              if (c[11:7] == 5'd0) x_instr = 32'h00100073; // c.ebreak
              else                 x_instr = {12'b0, c[11:7], 3'b000, 5'd1, OPC_JALR};
            end else begin // c.add
              x_instr = {7'b0, c[6:2], c[11:7], 3'b000, c[11:7], OPC_OP};
            end
          end
          3'b101: x_instr = {3'b0, c[9:7], c[12], c[6:2], 5'd2, 3'b011, c[11:10], 3'b000, OPC_STORE_FP};
          3'b110: x_instr = {4'b0, c[8:7], c[12], c[6:2], 5'd2, 3'b010, c[11:9], 2'b00, OPC_STORE};
          default: x_instr = {3'b0, c[9:7], c[12], c[6:2], 5'd2, 3'b011, c[11:10], 3'b000, OPC_STORE};
        endcase
      end
      default: x_instr = instr_i;
    endcase
  end

  always_comb begin
    is_compressed_o = (instr_i[1:0] != 2'b11);
    illegal_instr_o = 1'b0;
    instr_o         = instr_i;
    if (is_compressed_o) begin
      illegal_instr_o = x_ill;
      instr_o         = x_ill ? {16'h0, c} : x_instr;
    end
  end

endmodule

// File: rtl/fetch_realigner.sv
// Splits 32-bit fetch words into 16/32-bit instructions (incl. word-straddling ones) and expands them.
// Latency: word accepted in cycle N yields its first instruction on instr_valid_o in cycle N+2.
// Backpressure: instr_ready_i low holds the output register; fetch_ready_o drops until the buffered word is consumed.
// Ports: clk_i/rst_ni (async active-low), flush_i drops all buffered state; fetch_* valid/ready word input
//   (fetch_addr_i[1] selects start halfword); instr_* valid/ready expanded-instruction output with address,
//   is_compressed_o and illegal_instr_o. Optional FETCH_REALIGNER_STATS_EN adds cnt_compressed_o / cnt_straddle_o.
module fetch_realigner
  import fetch_realigner_pkg::*;
#(
  parameter int unsigned VLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            fetch_valid_i,
  output logic            fetch_ready_o,
  input  logic [31:0]     fetch_data_i,
  input  logic [VLEN-1:0] fetch_addr_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [31:0]     instr_o,
  output logic [VLEN-1:0] instr_addr_o,
  output logic            is_compressed_o,
`ifdef FETCH_REALIGNER_STATS_EN
  output logic [31:0]     cnt_compressed_o,
  output logic [31:0]     cnt_straddle_o,
`endif
  output logic            illegal_instr_o
);

  logic [31:0]          buf_q, buf_d;
  logic [VLEN-1:0]      buf_addr_q, buf_addr_d;
  logic                 buf_valid_q, buf_valid_d;
  logic                 hw_ptr_q, hw_ptr_d;
  logic [15:0]          strad_q, strad_d;
  logic [VLEN-1:0]      strad_addr_q, strad_addr_d;
  logic                 strad_valid_q, strad_valid_d;
  fetch_realign_entry_t out_q, out_d;
  logic                 out_valid_q, out_valid_d;

  logic            slot_free, step, accept;
  logic            emit, word_done, set_hw1, strad_emit, strad_cap;
  logic [31:0]     dec_in, dec_out;
  logic            dec_ill, dec_comp;
  logic [VLEN-1:0] emit_addr, upper_addr;

  assign slot_free  = !out_valid_q || instr_ready_i;
  assign step       = buf_valid_q && slot_free;
  // buf_addr_q is word-aligned, so the upper halfword address needs no adder.
  assign upper_addr = {buf_addr_q[VLEN-1:2], 2'b10};

  // Extract decision for the current buffered word, in priority order.
  always_comb begin
    dec_in     = 32'h0;
    emit_addr  = '0;
    emit       = 1'b0;
    word_done  = 1'b0;
    set_hw1    = 1'b0;
    strad_emit = 1'b0;
    strad_cap  = 1'b0;
    if (step) begin
      if (strad_valid_q) begin
        dec_in     = {buf_q[15:0], strad_q};
        emit_addr  = strad_addr_q;
        emit       = 1'b1;
        strad_emit = 1'b1;
        set_hw1    = 1'b1;
      end else if (!hw_ptr_q) begin
        emit_addr = buf_addr_q;
        emit      = 1'b1;
        if (buf_q[1:0] != 2'b11) begin
          dec_in  = {16'h0, buf_q[15:0]};
          set_hw1 = 1'b1;
        end else begin
          dec_in    = buf_q;
          word_done = 1'b1;
        end
      end else if (buf_q[17:16] != 2'b11) begin
        dec_in    = {16'h0, buf_q[31:16]};
        emit_addr = upper_addr;
        emit      = 1'b1;
        word_done = 1'b1;
      end else begin
        // Upper half begins a 32-bit instruction: park it until the next word.
        strad_cap = 1'b1;
        word_done = 1'b1;
      end
    end
  end

  compressed_decoder u_dec (
    .instr_i         (dec_in),
    .instr_o         (dec_out),
    .illegal_instr_o (dec_ill),
    .is_compressed_o (dec_comp)
  );

  assign fetch_ready_o = !flush_i && (!buf_valid_q || word_done);
  assign accept        = fetch_valid_i && fetch_ready_o;

  always_comb begin
    buf_d         = buf_q;
    buf_addr_d    = buf_addr_q;
    buf_valid_d   = buf_valid_q;
    hw_ptr_d      = hw_ptr_q;
    strad_d       = strad_q;
    strad_addr_d  = strad_addr_q;
    strad_valid_d = strad_valid_q;
    out_d         = out_q;
    out_valid_d   = out_valid_q;

    if (set_hw1)    hw_ptr_d      = 1'b1;
    if (strad_emit) strad_valid_d = 1'b0;
    if (strad_cap) begin
      strad_d       = buf_q[31:16];
      strad_addr_d  = upper_addr;
      strad_valid_d = 1'b1;
    end
    if (word_done) buf_valid_d = 1'b0;
    if (accept) begin
      buf_d       = fetch_data_i;
      buf_addr_d  = {fetch_addr_i[VLEN-1:2], 2'b00};
      hw_ptr_d    = fetch_addr_i[1];
      buf_valid_d = 1'b1;
    end

    if (slot_free) begin
      out_valid_d = emit;
      if (emit) begin
        out_d.addr          = FR_VLEN'(emit_addr);
        out_d.instr         = dec_out;
        out_d.is_compressed = dec_comp;
        out_d.illegal       = dec_ill;
      end
    end

    if (flush_i) begin
      buf_valid_d   = 1'b0;
      strad_valid_d = 1'b0;
      out_valid_d   = 1'b0;
      hw_ptr_d      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q         <= '0;
      buf_addr_q    <= '0;
      buf_valid_q   <= 1'b0;
      hw_ptr_q      <= 1'b0;
      strad_q       <= '0;
      strad_addr_q  <= '0;
      strad_valid_q <= 1'b0;
      out_q         <= '0;
      out_valid_q   <= 1'b0;
    end else begin
      buf_q         <= buf_d;
      buf_addr_q    <= buf_addr_d;
      buf_valid_q   <= buf_valid_d;
      hw_ptr_q      <= hw_ptr_d;
      strad_q       <= strad_d;
      strad_addr_q  <= strad_addr_d;
      strad_valid_q <= strad_valid_d;
      out_q         <= out_d;
      out_valid_q   <= out_valid_d;
    end
  end

  assign instr_valid_o   = out_valid_q;
  assign instr_o         = out_q.instr;
  assign instr_addr_o    = out_q.addr[VLEN-1:0];
  assign is_compressed_o = out_q.is_compressed;
  assign illegal_instr_o = out_q.illegal;

`ifdef FETCH_REALIGNER_STATS_EN
  logic [31:0] cnt_compressed_q, cnt_compressed_d;
  logic [31:0] cnt_straddle_q, cnt_straddle_d;

  // Counters survive flush; a straddle emit discarded by a same-cycle flush is not counted.
  always_comb begin
    cnt_compressed_d = cnt_compressed_q;
    cnt_straddle_d   = cnt_straddle_q;
    if (out_valid_q && instr_ready_i && out_q.is_compressed) cnt_compressed_d = cnt_compressed_q + 32'd1;
    if (strad_emit && !flush_i)                              cnt_straddle_d   = cnt_straddle_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_compressed_q <= '0;
      cnt_straddle_q   <= '0;
    end else begin
      cnt_compressed_q <= cnt_compressed_d;
      cnt_straddle_q   <= cnt_straddle_d;
    end
  end

  assign cnt_compressed_o = cnt_compressed_q;
  assign cnt_straddle_o   = cnt_straddle_q;
`endif

endmodule

// File: tb/tb_fetch_realigner.sv
// Directed bench for fetch_realigner: vector table for realign/expand cases, plus
// hand sequences for latency, backpressure, flush and asynchronous reset.
module tb_fetch_realigner;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        fetch_valid_i;
  logic        fetch_ready_o;
  logic [31:0] fetch_data_i;
  logic [63:0] fetch_addr_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [63:0] instr_addr_o;
  logic        is_compressed_o;
  logic        illegal_instr_o;
`ifdef FETCH_REALIGNER_STATS_EN
  logic [31:0] cnt_compressed_o;
  logic [31:0] cnt_straddle_o;
`endif

  always #5 clk_i = ~clk_i;

  fetch_realigner #(.VLEN(64)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .flush_i         (flush_i),
    .fetch_valid_i   (fetch_valid_i),
    .fetch_ready_o   (fetch_ready_o),
    .fetch_data_i    (fetch_data_i),
    .fetch_addr_i    (fetch_addr_i),
    .instr_valid_o   (instr_valid_o),
    .instr_ready_i   (instr_ready_i),
    .instr_o         (instr_o),
    .instr_addr_o    (instr_addr_o),
    .is_compressed_o (is_compressed_o),
`ifdef FETCH_REALIGNER_STATS_EN
    .cnt_compressed_o(cnt_compressed_o),
    .cnt_straddle_o  (cnt_straddle_o),
`endif
    .illegal_instr_o (illegal_instr_o)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] addr;
    logic        comp;
    logic        ill;
  } exp_t;

  typedef struct packed {
    logic [1:0]      nw;
    logic [31:0]     d0;
    logic [63:0]     a0;
    logic [31:0]     d1;
    logic [63:0]     a1;
    logic [1:0]      ne;
    exp_t [0:2]      e;
  } vec_t;

  localparam exp_t NONE = '0;
  localparam int   NVEC = 6;

  vec_t vecs[NVEC];
  exp_t got_q[$];
  int   tests = 0;
  int   fails = 0;

  // Record every completed output handshake.
  always @(negedge clk_i) begin
    exp_t g;
    if (rst_ni && instr_valid_o && instr_ready_i) begin
      g.instr = instr_o;
      g.addr  = instr_addr_o;
      g.comp  = is_compressed_o;
      g.ill   = illegal_instr_o;
      got_q.push_back(g);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic do_flush();
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
  endtask

  // Present a word until accepted; returns #1 after the accepting edge.
  task automatic send_word(input logic [31:0] d, input logic [63:0] a);
    bit ok = 0;
    fetch_valid_i = 1'b1;
    fetch_data_i  = d;
    fetch_addr_i  = a;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk_i);
      if (fetch_ready_o) ok = 1;
      @(posedge clk_i);
      #1;
    end
    fetch_valid_i = 1'b0;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL send_timeout: actual=not_accepted required=accepted addr=0x%0h", a);
    end
  endtask

  initial begin
    vecs[0] = '{nw:2'd1, d0:32'h45854501, a0:64'h1000, d1:32'h0, a1:64'h0, ne:2'd2,
                e:'{'{32'h00000513, 64'h1000, 1'b1, 1'b0}, '{32'h00100593, 64'h1002, 1'b1, 1'b0}, NONE}};
    vecs[1] = '{nw:2'd1, d0:32'h00A00513, a0:64'h2000, d1:32'h0, a1:64'h0, ne:2'd1,
                e:'{'{32'h00A00513, 64'h2000, 1'b0, 1'b0}, NONE, NONE}};
    vecs[2] = '{nw:2'd2, d0:32'h05134501, a0:64'h3000, d1:32'h458500A0, a1:64'h3004, ne:2'd3,
                e:'{'{32'h00000513, 64'h3000, 1'b1, 1'b0}, '{32'h00A00513, 64'h3002, 1'b0, 1'b0},
                    '{32'h00100593, 64'h3006, 1'b1, 1'b0}}};
    vecs[3] = '{nw:2'd1, d0:32'h4585FFFF, a0:64'h4002, d1:32'h0, a1:64'h0, ne:2'd1,
                e:'{'{32'h00100593, 64'h4002, 1'b1, 1'b0}, NONE, NONE}};
    vecs[4] = '{nw:2'd1, d0:32'h00008082, a0:64'h7000, d1:32'h0, a1:64'h0, ne:2'd2,
                e:'{'{32'h00008067, 64'h7000, 1'b1, 1'b0}, '{32'h00000000, 64'h7002, 1'b1, 1'b1}, NONE}};
    vecs[5] = '{nw:2'd1, d0:32'h157D852E, a0:64'h7101, d1:32'h0, a1:64'h0, ne:2'd2,
                e:'{'{32'h00B00533, 64'h7100, 1'b1, 1'b0}, '{32'hFFF50513, 64'h7102, 1'b1, 1'b0}, NONE}};

    rst_ni        = 1'b0;
    flush_i       = 1'b0;
    fetch_valid_i = 1'b0;
    fetch_data_i  = '0;
    fetch_addr_i  = '0;
    instr_ready_i = 1'b0;
    wait_cycles(3);

    check("rst_valid", instr_valid_o, 0);
    check("rst_instr", instr_o, 0);
    check("rst_addr", instr_addr_o, 0);
    check("rst_comp", is_compressed_o, 0);
    check("rst_ill", illegal_instr_o, 0);
    rst_ni = 1'b1;
    wait_cycles(1);
    check("ready_after_reset", fetch_ready_o, 1);

    // Latency and refill: first instruction at N+2, ready returns on second extract.
    instr_ready_i = 1'b1;
    send_word(32'h45854501, 64'h1000);
    @(negedge clk_i);
    check("lat_n1_valid", instr_valid_o, 0);
    check("lat_n1_ready", fetch_ready_o, 0);
    @(negedge clk_i);
    check("lat_n2_valid", instr_valid_o, 1);
    check("lat_n2_instr", instr_o, 32'h00000513);
    check("lat_n2_ready", fetch_ready_o, 1);
    @(posedge clk_i);
    #1;
    wait_cycles(6);

    for (int i = 0; i < NVEC; i++) begin
      do_flush();
      got_q.delete();
      send_word(vecs[i].d0, vecs[i].a0);
      if (vecs[i].nw == 2'd2) send_word(vecs[i].d1, vecs[i].a1);
      wait_cycles(8);
      check($sformatf("v%0d_count", i), got_q.size(), vecs[i].ne);
      for (int j = 0; j < int'(vecs[i].ne); j++) begin
        if (j < got_q.size()) begin
          check($sformatf("v%0d_o%0d_instr", i, j), got_q[j].instr, vecs[i].e[j].instr);
          check($sformatf("v%0d_o%0d_addr", i, j), got_q[j].addr, vecs[i].e[j].addr);
          check($sformatf("v%0d_o%0d_comp", i, j), got_q[j].comp, vecs[i].e[j].comp);
          check($sformatf("v%0d_o%0d_ill", i, j), got_q[j].ill, vecs[i].e[j].ill);
        end
      end
    end

    // Backpressure with an illegal halfword held on the output.
    do_flush();
    got_q.delete();
    instr_ready_i = 1'b0;
    send_word(32'h00000000, 64'h6000);
    @(negedge clk_i);
    @(negedge clk_i);
    check("bp_valid", instr_valid_o, 1);
    check("bp_instr", instr_o, 0);
    check("bp_ill", illegal_instr_o, 1);
    check("bp_addr", instr_addr_o, 64'h6000);
    @(posedge clk_i);
    #1;
    fetch_valid_i = 1'b1;
    fetch_data_i  = 32'h00A00513;
    fetch_addr_i  = 64'h6100;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check($sformatf("bp_hold%0d_valid", k), instr_valid_o, 1);
      check($sformatf("bp_hold%0d_ill", k), illegal_instr_o, 1);
      check($sformatf("bp_hold%0d_addr", k), instr_addr_o, 64'h6000);
      check($sformatf("bp_hold%0d_fready", k), fetch_ready_o, 0);
      @(posedge clk_i);
      #1;
    end
    instr_ready_i = 1'b1;
    send_word(32'h00A00513, 64'h6100);
    wait_cycles(8);
    check("bp_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check("bp_o0_addr", got_q[0].addr, 64'h6000);
      check("bp_o1_addr", got_q[1].addr, 64'h6002);
      check("bp_o1_ill", got_q[1].ill, 1);
      check("bp_o2_instr", got_q[2].instr, 32'h00A00513);
      check("bp_o2_addr", got_q[2].addr, 64'h6100);
    end

    // Flush discards a pending straddle and blocks a word presented in the flush cycle.
    do_flush();
    got_q.delete();
    send_word(32'h05134501, 64'h3000);
    wait_cycles(4);
    flush_i       = 1'b1;
    fetch_valid_i = 1'b1;
    fetch_data_i  = 32'h00A00513;
    fetch_addr_i  = 64'h5000;
    @(negedge clk_i);
    check("flush_fready", fetch_ready_o, 0);
    @(posedge clk_i);
    #1;
    flush_i       = 1'b0;
    fetch_valid_i = 1'b0;
    check("flush_post_valid", instr_valid_o, 0);
    send_word(32'h00A00513, 64'h5000);
    wait_cycles(8);
    check("flush_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("flush_o1_instr", got_q[1].instr, 32'h00A00513);
      check("flush_o1_addr", got_q[1].addr, 64'h5000);
      check("flush_o1_comp", got_q[1].comp, 0);
    end

    // Asynchronous reset while an output is stalled.
    instr_ready_i = 1'b0;
    send_word(32'h45854501, 64'h1000);
    wait_cycles(3);
    check("prerst_valid", instr_valid_o, 1);
    rst_ni = 1'b0;
    #1;
    check("arst_valid", instr_valid_o, 0);
    check("arst_instr", instr_o, 0);
    check("arst_addr", instr_addr_o, 0);
    wait_cycles(1);
    rst_ni = 1'b1;
    wait_cycles(2);
    check("arst_post_valid", instr_valid_o, 0);
    check("arst_post_fready", fetch_ready_o, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
